// File: rtl/ysyx_22040632_dc_uncache_resp_if.sv
// Bus bundle between the MEM-stage uncached request port, the responder and its AXI4 master side.
// "master" is the responder's view; "slave" is the environment (MEM stage plus AXI slave).
interface ysyx_22040632_dc_uncache_resp_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  // MEM-stage request / response
  logic                valid;
  logic                req;
  logic [ADDR_W-1:0]   addr;
  logic [2:0]          size;
  logic [DATA_W/8-1:0] wmask_uncacheble;
  logic [DATA_W-1:0]   data_write;
  logic                ready;
  logic [DATA_W-1:0]   data_read;
  logic                err;

  // AXI4 read channels
  logic                arvalid;
  logic                arready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arsize;
  logic                rvalid;
  logic                rready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;

  // AXI4 write channels
  logic                awvalid;
  logic                awready;
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awsize;
  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                bvalid;
  logic                bready;
  logic [1:0]          bresp;

  modport master (
    input  valid, req, addr, size, wmask_uncacheble, data_write,
    output ready, data_read, err,
    output arvalid, araddr, arsize, rready,
    input  arready, rvalid, rdata, rresp,
    output awvalid, awaddr, awsize, wvalid, wdata, wstrb, wlast, bready,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    output valid, req, addr, size, wmask_uncacheble, data_write,
    input  ready, data_read, err,
    input  arvalid, araddr, arsize, rready,
    output arready, rvalid, rdata, rresp,
    input  awvalid, awaddr, awsize, wvalid, wdata, wstrb, wlast, bready,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/ysyx_22040632_dc_uncache_resp.sv
// Uncached data-request responder: turns one MEM-stage load/store into a single-beat
// AXI4 transaction and returns a one-cycle ready pulse with byte-0-aligned load data.
module ysyx_22040632_dc_uncache_resp #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input logic                            clk,
  input logic                            rrst_n,
  ysyx_22040632_dc_uncache_resp_if.master bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_D,
    WR_AW,
    WR_B,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        size_q;
  logic [STRB_W-1:0] strb_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              aw_done_q;
  logic              w_done_q;
  logic              err_q;

  logic arvalid, rready, awvalid, wvalid, bready, ready, err;
  logic accept;

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // AW and W complete independently; the per-channel done flags let each valid
  // drop on its own handshake while the state waits for the second one.
  always_comb begin
    state_d = state_q;
    arvalid = 1'b0;
    rready  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    ready   = 1'b0;
    err     = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.valid) begin
          accept  = 1'b1;
          state_d = bus.req ? WR_AW : RD_A;
        end
      end
      RD_A: begin
        arvalid = 1'b1;
        if (bus.arready) state_d = RD_D;
      end
      RD_D: begin
        rready = 1'b1;
        if (bus.rvalid) state_d = DONE;
      end
      WR_AW: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        if ((aw_done_q || bus.awready) && (w_done_q || bus.wready)) state_d = WR_B;
      end
      WR_B: begin
        bready = 1'b1;
        if (bus.bvalid) state_d = DONE;
      end
      DONE: begin
        ready   = 1'b1;
        err     = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      addr_q    <= '0;
      size_q    <= '0;
      strb_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        addr_q    <= bus.addr;
        size_q    <= bus.size;
        strb_q    <= bus.wmask_uncacheble;
        wdata_q   <= bus.data_write;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        err_q     <= 1'b0;
      end
      if (awvalid && bus.awready) aw_done_q <= 1'b1;
      if (wvalid && bus.wready)   w_done_q  <= 1'b1;
      if (rready && bus.rvalid) begin
        rdata_q <= bus.rdata >> {addr_q[OFF_W-1:0], 3'b000};
        err_q   <= (bus.rresp != 2'b00);
      end
      if (bready && bus.bvalid) err_q <= (bus.bresp != 2'b00);
    end
  end

  assign bus.ready     = ready;
  assign bus.err       = err;
  assign bus.data_read = rdata_q;

  assign bus.arvalid = arvalid;
  assign bus.araddr  = addr_q;
  assign bus.arsize  = size_q;
  assign bus.rready  = rready;

  assign bus.awvalid = awvalid;
  assign bus.awaddr  = addr_q;
  assign bus.awsize  = size_q;
  assign bus.wvalid  = wvalid;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = strb_q;
  assign bus.wlast   = 1'b1;
  assign bus.bready  = bready;
endmodule

// File: doc/ysyx_22040632_dc_uncache_resp.md
Name: ysyx_22040632_dc_uncache_resp

Overview:
- Responder end of the MEM-stage data request interface (valid/ready, req, addr, size, byte strobe, write data, read data).
- Accepts one uncacheable load or store at a time from the MEM stage.
- Converts it to a single-beat AXI4 master transaction: AR/R for reads, AW/W/B for writes.
- Returns a one-cycle ready pulse, with read data right-aligned to byte 0.
- Sits between the MEM stage and the AXI arbiter, in parallel with the cacheable dcache path.

Parameters:
- ADDR_W, 32, request/AXI address width
- DATA_W, 64, data bus width; a power of two ≥ 16

Ports:
- clk  in  1  clock
- rrst_n  in  1  reset, asynchronous, active-low
- valid  in  1  request valid; held by the requester until ready
- req  in  1  0 = read (REQ_READ), 1 = write (REQ_WRITE)
- addr  in  ADDR_W  byte address
- size  in  3  AXI size code (000 = 1 B … 011 = 8 B)
- wmask_uncacheble  in  DATA_W/8  byte strobe, already lane-positioned
- data_write  in  DATA_W  write data, already lane-shifted by addr[2:0]
- ready  out  1  one-cycle completion pulse
- data_read  out  DATA_W  load data, shifted down to byte 0
- err  out  1  pulses with ready when the AXI response ≠ OKAY
- arvalid/arready  out/in  1  AXI read-address handshake
- araddr  out  ADDR_W  read address
- arsize  out  3  read size
- rvalid/rready  in/out  1  AXI read-data handshake
- rdata  in  DATA_W  read data
- rresp  in  2  read response
- awvalid/awready  out/in  1  AXI write-address handshake
- awaddr  out  ADDR_W  write address
- awsize  out  3  write size
- wvalid/wready  out/in  1  AXI write-data handshake
- wdata  out  DATA_W  write data
- wstrb  out  DATA_W/8  write strobe
- wlast  out  1  constant 1
- bvalid/bready  in/out  1  AXI write-response handshake
- bresp  in  2  write response

Behaviour:
- Reset values (async on rrst_n low): all outputs 0; data_read = 0; state = IDLE.
- Reset mid-transaction aborts immediately with no further AXI handshakes.
- States: IDLE, RD_A, RD_D, WR_AW, WR_B, DONE.
- IDLE: when valid = 1, latch req, addr, size, wmask_uncacheble, data_write into internal registers.
  - All AXI fields are driven from these latches only; upstream addr may change after acceptance.
  - req = 0 → RD_A with arvalid = 1.
  - req = 1 → WR_AW with awvalid = 1 and wvalid = 1.
- RD_A: hold arvalid and araddr/arsize stable until arready; on the handshake, arvalid → 0 and go to RD_D with rready = 1.
- RD_D: on rvalid & rready:
  - data_read ← rdata >> (addr_lat[2:0]·8), zero-filled at the top.
  - err_lat ← (rresp ≠ 00).
  - rready → 0; go to DONE.
- WR_AW: AW and W handshakes are independent.
  - Each valid drops on its own handshake.
  - Both may complete in the same cycle or in either order.
  - When both have completed → WR_B with bready = 1.
- WR_B: on bvalid & bready: err_lat ← (bresp ≠ 00); bready → 0; go to DONE. data_read is unchanged.
- DONE: ready = 1 and err = err_lat for exactly this one cycle, then → IDLE.
  - valid is ignored in DONE; the requester deasserts it on the same edge.
- A new request can be accepted one cycle after DONE (back-to-back throughput).
- data_read holds its value until the next read's R handshake; stores never modify it.
- Minimum latency, valid to ready:
  - Read: 3 cycles (IDLE accept → RD_A → RD_D → DONE) with arready and rvalid combinationally high.
  - Write: 3 cycles.
- valid seen in RD_*/WR_* states is ignored; no second request is queued.
- wdata/wstrb pass through unmodified; no alignment checks are made.

Test Plan:
- Read ld at 0x8000_0008, size 011, rdata = 0x1122334455667788, slaves always ready → ready pulses 3 cycles after accept; data_read = 0x1122334455667788; err = 0.
- Read lb at 0x1000_0005, rdata = 0xAABBCCDDEEFF0011 → data_read = 0x0000_0000_00AA_BBCC; arsize = 000; araddr = 0x1000_0005.
- Store sw at 0x1000_0004, data_write = 0xDEADBEEF_00000000, strobe = 0xF0; awready delayed 4 cycles, wready immediate → wvalid drops after 1 cycle, awvalid after 4, then bready; ready exactly 1 cycle; wstrb = 0xF0.
- Write with bresp = 10 → err = 1 coincident with ready; the following read with rresp = 00 → err = 0.
- Change addr from 0x100 to 0x200 the cycle after accept → araddr stays 0x100 until the AR handshake.
- Assert rrst_n low during RD_D → all valids/readies 0 asynchronously; after release, a new read completes normally.
